// File: rtl/rle_arb_pkg.sv
// Shared encodings for the RLE line arbiter: FSM states, colour values and
// handshake levels of the dav_/rfd four-phase protocol.
package rle_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] REL  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_FWD  = FWD,
        S_REL  = REL
    } state_t;

    localparam logic bianco = 1'b0;
    localparam logic nero   = 1'b1;

    localparam logic dav_active = 1'b0;
    localparam logic dav_idle   = 1'b1;
    localparam logic rfd_ready  = 1'b1;
    localparam logic rfd_taken  = 1'b0;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin request picker: scans from prio with wrap-around, or considers
// only the current owner while a line is locked.
module rr_priority_picker #(
    parameter int N_REQ = 2,
    parameter int IDW   = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   prio,
    input  logic             lock,
    input  logic [IDW-1:0]   owner,
    output logic             hit,
    output logic [IDW-1:0]   winner
);

    always_comb begin
        int idx;
        idx    = 0;
        hit    = 1'b0;
        winner = '0;
        if (lock) begin
            hit    = req[owner];
            winner = owner;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = int'(prio) + i;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!hit && req[idx]) begin
                    hit    = 1'b1;
                    winner = idx[IDW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/rle_line_arbiter.sv
// Shares one RLE line encoder between N_REQ pixel sources; a grant lasts a
// whole line (until an endline pixel is forwarded), next owner round-robin.
module rle_line_arbiter
    import rle_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = 1,
    parameter int LCW   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] dav_in_,
    input  logic [N_REQ-1:0] colore_in,
    input  logic [N_REQ-1:0] endline_in,
    output logic [N_REQ-1:0] rfd_out,
    output logic             dav_,
    output logic             colore,
    output logic             endline,
    input  logic             rfd,
    output logic [IDW-1:0]   owner,
    output logic             locked,
    output logic [LCW-1:0]   line_count
);

    state_t         state;
    logic [IDW-1:0] prio;
    logic [IDW-1:0] next_prio;
    logic           hit;
    logic [IDW-1:0] winner;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_picker (
        .req    (~dav_in_),
        .prio   (prio),
        .lock   (locked),
        .owner  (owner),
        .hit    (hit),
        .winner (winner)
    );

    assign next_prio = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            dav_       <= dav_idle;
            colore     <= nero;
            endline    <= 1'b0;
            rfd_out    <= '1;
            owner      <= '0;
            locked     <= 1'b0;
            line_count <= '0;
            prio       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        colore  <= colore_in[winner];
                        endline <= endline_in[winner];
                        owner   <= winner;
                        locked  <= 1'b1;
                        state   <= S_FWD;
                    end
                end
                // dav_ drops on the first FWD cycle; the encoder's rfd is
                // only trusted once our own dav_ is already low.
                S_FWD: begin
                    if (dav_ == dav_active && rfd == rfd_taken) begin
                        dav_           <= dav_idle;
                        rfd_out[owner] <= rfd_taken;
                        state          <= S_REL;
                    end else begin
                        dav_ <= dav_active;
                    end
                end
                S_REL: begin
                    if (dav_in_[owner] == dav_idle && rfd == rfd_ready) begin
                        rfd_out[owner] <= rfd_ready;
                        if (endline) begin
                            locked     <= 1'b0;
                            prio       <= next_prio;
                            line_count <= line_count + 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_line_arbiter.sv
// Scoreboard bench for rle_line_arbiter: two source models, an encoder model
// that pops expected transfers on each accepted pixel, and directed line tests.
module tb_rle_line_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] dav_in_;
    logic [1:0] colore_in;
    logic [1:0] endline_in;
    logic [1:0] rfd_out;
    logic       dav_;
    logic       colore;
    logic       endline;
    logic       rfd;
    logic       owner;
    logic       locked;
    logic [1:0] line_count;

    rle_line_arbiter #(
        .N_REQ (2),
        .IDW   (1),
        .LCW   (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dav_in_    (dav_in_),
        .colore_in  (colore_in),
        .endline_in (endline_in),
        .rfd_out    (rfd_out),
        .dav_       (dav_),
        .colore     (colore),
        .endline    (endline),
        .rfd        (rfd),
        .owner      (owner),
        .locked     (locked),
        .line_count (line_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic own;
        logic col;
        logic endl;
    } xfer_t;

    xfer_t      sb[$];
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         enc_stall = 0;
    logic [1:0] src_hold = 2'b00;
    int         sst[2];
    logic       seen[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Source models: drop dav_in_, wait for rfd_out low, raise, wait rfd_out high.
    initial begin
        logic [1:0] px;
        logic       have;
        dav_in_    = 2'b11;
        colore_in  = 2'b00;
        endline_in = 2'b00;
        sst[0] = 0; sst[1] = 0;
        seen[0] = 1'b0; seen[1] = 1'b0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                case (sst[i])
                    0: begin
                        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        if (have) begin
                            px = (i == 0) ? q0[0] : q1[0];
                            colore_in[i]  = px[1];
                            endline_in[i] = px[0];
                            dav_in_[i]    = 1'b0;
                            seen[i]       = 1'b0;
                            sst[i]        = 1;
                        end
                    end
                    1: begin
                        if (!rfd_out[i]) seen[i] = 1'b1;
                        if (seen[i] && !src_hold[i]) begin
                            dav_in_[i] = 1'b1;
                            sst[i]     = 2;
                        end
                    end
                    default: begin
                        if (rfd_out[i]) begin
                            if (i == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                            sst[i] = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Encoder model and scoreboard monitor.
    initial begin
        xfer_t snap;
        xfer_t exp;
        int    w;
        rfd = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset && !dav_ && rfd) begin
                snap = '{own: owner, col: colore, endl: endline};
                repeat (enc_stall) begin
                    @(negedge clock);
                    check("stall_dav", dav_, 0);
                    check("stall_colore", colore, snap.col);
                    check("stall_endline", endline, snap.endl);
                    check("stall_rfd_out", rfd_out[snap.own], 1);
                end
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_xfer: got owner %0d colore %0d endline %0d, required none", owner, colore, endline);
                end else begin
                    exp = sb.pop_front();
                    check("xfer_owner", owner, exp.own);
                    check("xfer_colore", colore, exp.col);
                    check("xfer_endline", endline, exp.endl);
                end
                rfd = 1'b0;
                w = 0;
                while (dav_ !== 1'b1 && w < 1000) begin
                    @(negedge clock);
                    w++;
                end
                if (w >= 1000) begin
                    n_chk++;
                    $display("FAIL enc_release_timeout: dav_ %0b, required 1", dav_);
                end
                rfd = 1'b1;
            end
        end
    end

    // Only the owner's rfd_out may ever leave 1.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset)
                for (int i = 0; i < 2; i++)
                    if (i != int'(owner)) check("non_owner_rfd_out", rfd_out[i], 1);
        end
    end

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!(sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && sst[0] == 0 && sst[1] == 0) && w < 2000) begin
            @(negedge clock);
            w++;
        end
        if (w >= 2000) begin
            n_chk++;
            $display("FAIL %s_timeout: %0d transfers outstanding, required 0", tag, sb.size());
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int          w;
        logic        b;
        logic [1:0]  lc_exp[5];
        lc_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_dav_", dav_, 1);
        check("rst_colore", colore, 1);
        check("rst_endline", endline, 0);
        check("rst_rfd_out", rfd_out, 2'b11);
        check("rst_owner", owner, 0);
        check("rst_locked", locked, 0);
        check("rst_line_count", line_count, 0);
        reset = 1'b0;

        // single source: n,n,n then endline
        sb.push_back(xfer_t'{1'b0, 1'b1, 1'b0});
        sb.push_back(xfer_t'{1'b0, 1'b1, 1'b0});
        sb.push_back(xfer_t'{1'b0, 1'b1, 1'b0});
        sb.push_back(xfer_t'{1'b0, 1'b0, 1'b1});
        q0.push_back(2'b10); q0.push_back(2'b10); q0.push_back(2'b10); q0.push_back(2'b01);
        wait_done("t1");
        check("t1_line_count", line_count, 1);
        check("t1_locked", locked, 0);
        check("t1_prio", dut.prio, 1);

        // simultaneous requests after reset: src0 line first, then src1
        do_reset();
        sb.push_back(xfer_t'{1'b0, 1'b0, 1'b0});
        sb.push_back(xfer_t'{1'b0, 1'b1, 1'b1});
        sb.push_back(xfer_t'{1'b1, 1'b1, 1'b0});
        sb.push_back(xfer_t'{1'b1, 1'b0, 1'b1});
        q0.push_back(2'b00); q0.push_back(2'b11);
        q1.push_back(2'b10); q1.push_back(2'b01);
        wait_done("t2");
        check("t2_line_count", line_count, 2);
        check("t2_locked", locked, 0);
        check("t2_prio", dut.prio, 0);

        // lock hold: src1 requests in the middle of src0's line
        sb.push_back(xfer_t'{1'b0, 1'b1, 1'b0});
        sb.push_back(xfer_t'{1'b0, 1'b0, 1'b0});
        sb.push_back(xfer_t'{1'b0, 1'b1, 1'b1});
        sb.push_back(xfer_t'{1'b1, 1'b1, 1'b1});
        q0.push_back(2'b10); q0.push_back(2'b00); q0.push_back(2'b11);
        w = 0;
        while (sb.size() > 3 && w < 500) begin
            @(negedge clock);
            w++;
        end
        check("t3_first_pixel_taken", (sb.size() <= 3), 1);
        q1.push_back(2'b11);
        wait_done("t3");
        check("t3_line_count", line_count, 0);
        check("t3_owner", owner, 1);

        // encoder stall of 20 cycles
        enc_stall = 20;
        sb.push_back(xfer_t'{1'b0, 1'b1, 1'b1});
        q0.push_back(2'b11);
        wait_done("t4");
        enc_stall = 0;
        check("t4_line_count", line_count, 1);

        // reset while src0 sits in REL
        src_hold[0] = 1'b1;
        sb.push_back(xfer_t'{1'b0, 1'b0, 1'b0});
        q0.push_back(2'b00);
        w = 0;
        while (rfd_out[0] !== 1'b0 && w < 500) begin
            @(negedge clock);
            w++;
        end
        check("t5_pre_rfd_out", rfd_out, 2'b10);
        check("t5_pre_locked", locked, 1);
        reset = 1'b1;
        #1;
        check("t5_dav_", dav_, 1);
        check("t5_rfd_out", rfd_out, 2'b11);
        check("t5_locked", locked, 0);
        check("t5_line_count", line_count, 0);
        check("t5_colore", colore, 1);
        check("t5_endline", endline, 0);
        @(negedge clock);
        src_hold[0] = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        sb.push_back(xfer_t'{1'b1, 1'b1, 1'b1});
        q1.push_back(2'b11);
        wait_done("t5");
        check("t5_post_owner", owner, 1);
        check("t5_post_line_count", line_count, 1);

        // line_count wrap with LCW=2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            b = k[0];
            sb.push_back(xfer_t'{1'b0, b, 1'b1});
            q0.push_back({b, 1'b1});
            wait_done("t6");
            check("t6_line_count", line_count, lc_exp[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
